// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the IF->ID instruction queue: default depth and the
// 65-bit entry layout {pc[64:33], inst[32:1], adef[0]} used by if_to_id_bus.
package inst_fetch_queue_pkg;

    localparam int IFQ_DEPTH    = 4;
    localparam int IFQ_ENTRY_WD = 65;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_regfile.sv
// Entry storage for inst_fetch_queue: synchronous write, asynchronous read,
// asynchronous active-low clear of every entry.
module ifq_regfile
    import inst_fetch_queue_pkg::*;
#(
    parameter  int DEPTH = IFQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    we,
    input  logic [PTR_W-1:0]        waddr,
    input  logic [IFQ_ENTRY_WD-1:0] wdata,
    input  logic [PTR_W-1:0]        raddr,
    output logic [IFQ_ENTRY_WD-1:0] rdata
);

    logic [IFQ_ENTRY_WD-1:0] mem_q [DEPTH];
    logic [IFQ_ENTRY_WD-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction queue between IF and ID with flush. Define IFQ_BYPASS_EN to let an
// entry arriving at an empty queue reach ID in the same cycle.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter  int DEPTH = IFQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    input  logic             in_adef,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    output logic             out_adef,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push, pop, q_empty;
    ifq_entry_t       wr_entry, rd_entry, out_entry;

    assign q_empty  = (cnt_q == '0);
    assign in_ready = (cnt_q != CNT_FULL) & ~flush;
    assign wr_entry = '{pc: in_pc, inst: in_inst, adef: in_adef};

`ifdef IFQ_BYPASS_EN
    logic bypass;

    // An entry meeting an empty queue is presented directly; it is stored only
    // if ID does not take it this cycle.
    assign bypass    = q_empty & in_valid & ~flush;
    assign out_valid = (~q_empty | in_valid) & ~flush;
    assign out_entry = bypass ? wr_entry : rd_entry;
    assign pop       = out_valid & out_ready & ~bypass;
    assign push      = in_valid & in_ready & ~(bypass & out_ready);
`else
    assign out_valid = ~q_empty & ~flush;
    assign out_entry = rd_entry;
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & in_ready;
`endif

    assign out_pc   = out_entry.pc;
    assign out_inst = out_entry.inst;
    assign out_adef = out_entry.adef;
    assign count    = cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            // Stored entries are left in place; resetting the pointers hides them.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
                2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    ifq_regfile #(.DEPTH(DEPTH)) u_regfile (
        .clk    (clk),
        .resetn (resetn),
        .we     (push),
        .waddr  (wr_ptr_q),
        .wdata  (wr_entry),
        .raddr  (rd_ptr_q),
        .rdata  (rd_entry)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    localparam int DEPTH = IFQ_DEPTH;
    localparam int PW    = $clog2(DEPTH);
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_pc = '0;
    logic [31:0]   in_inst = '0;
    logic          in_adef = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_pc;
    logic [31:0]   out_inst;
    logic          out_adef;
    logic [PW:0]   count;

    int errors = 0;
    int checks = 0;
    logic [64:0] q[$];

    always #5 clk = ~clk;

    inst_fetch_queue dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_adef   (in_adef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_adef  (out_adef),
        .count     (count)
    );

    // Reference model: what the queue should present given the current inputs.
    function automatic bit m_ov();
        return !flush && (q.size() != 0 || (BYP && in_valid));
    endfunction

    function automatic bit m_ir();
        return !flush && (q.size() != DEPTH);
    endfunction

    function automatic logic [64:0] m_head();
        if (q.size() != 0) return q[0];
        return {in_pc, in_inst, in_adef};
    endfunction

    // Apply one clock edge, advancing the model from the pre-edge inputs.
    task automatic tick();
        bit ov = m_ov();
        bit ir = m_ir();
        logic [64:0] e;
        if (!resetn) begin
            q.delete();
        end else if (flush) begin
            q.delete();
            $display("flush  t=%0t", $time);
        end else if (q.size() == 0 && BYP && in_valid && out_ready) begin
            $display("bypass pc=%h adef=%0b", in_pc, in_adef);
        end else begin
            if (ov && out_ready) begin
                e = q.pop_front();
                $display("pop    pc=%h adef=%0b", e[64:33], e[0]);
            end
            if (in_valid && ir) begin
                q.push_back({in_pc, in_inst, in_adef});
                $display("push   pc=%h adef=%0b", in_pc, in_adef);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_pc !== 32'h0)    begin errors++; $display("FAIL rst_out_pc got=%h exp=0", out_pc); end
        checks++; if (out_inst !== 32'h0)  begin errors++; $display("FAIL rst_out_inst got=%h exp=0", out_inst); end
        checks++; if (out_adef !== 1'b0)   begin errors++; $display("FAIL rst_out_adef got=%b exp=0", out_adef); end
        checks++; if (count !== '0)        begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h1c000000;
        in_inst   = 32'h02800c0c;
        in_adef   = 1'b0;
        #1;
        checks++; if (out_valid !== BYP) begin errors++; $display("FAIL single_same_cycle got=%b exp=%b", out_valid, BYP); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== !BYP) begin errors++; $display("FAIL single_next_cycle got=%b exp=%b", out_valid, !BYP); end
        checks++; if (!BYP && {out_pc, out_inst} !== {32'h1c000000, 32'h02800c0c}) begin
            errors++; $display("FAIL single_data got=%h/%h exp=1c000000/02800c0c", out_pc, out_inst);
        end
        tick();
        checks++; if (count !== '0) begin errors++; $display("FAIL single_drained got=%0d exp=0", count); end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h1c000000 + 32'(4 * i);
            in_inst  = ~in_pc;
            in_adef  = 1'b0;
            #1;
            checks++; if (in_ready !== (i < DEPTH)) begin
                errors++; $display("FAIL fill_in_ready i=%0d got=%b exp=%b", i, in_ready, (i < DEPTH));
            end
            tick();
        end
        checks++; if (count !== (PW + 1)'(DEPTH)) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", count, DEPTH); end
        checks++; if (out_pc !== 32'h1c000000) begin errors++; $display("FAIL fill_head got=%h exp=1c000000", out_pc); end
    endtask

    task automatic test_stream();
        int push_idx = 4;
        int pop_idx  = 0;
        int cyc      = 0;
        bit acc, popped;
        out_ready = 1'b1;
        while (pop_idx < 24 && cyc < 200) begin
            in_valid = (push_idx < 24);
            in_pc    = 32'h1c000000 + 32'(4 * push_idx);
            in_inst  = ~in_pc;
            #1;
            if (m_ov()) begin
                checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1c000000 + 32'(4 * pop_idx)) begin
                    errors++; $display("FAIL stream_order idx=%0d got=%b/%h exp=1/%h", pop_idx, out_valid, out_pc, 32'h1c000000 + 32'(4 * pop_idx));
                end
            end
            acc    = in_valid && m_ir();
            popped = m_ov() && out_ready;
            tick();
            if (acc)    push_idx++;
            if (popped) pop_idx++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (pop_idx != 24) begin errors++; $display("FAIL stream_timeout got=%0d exp=24", pop_idx); end
        #1;
        checks++; if (count !== '0) begin errors++; $display("FAIL stream_drained got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h1c004000 + 32'(4 * i);
            in_inst  = 32'h0;
            tick();
        end
        flush   = 1'b1;
        in_pc   = 32'h1c00dead;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (count !== '0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_after got=%0d/%b exp=0/0", count, out_valid);
        end
        in_valid  = 1'b1;
        in_pc     = 32'h1c008000;
        in_inst   = 32'h12345678;
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== BYP) begin errors++; $display("FAIL flush_push_same got=%b exp=%b", out_valid, BYP); end
        if (!BYP) begin
            tick();
            in_valid = 1'b0;
            #1;
        end
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1c008000) begin
            errors++; $display("FAIL flush_next_out got=%b/%h exp=1/1c008000", out_valid, out_pc);
        end
        tick();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic test_adef();
        logic [31:0] pcs[3];
        logic        adfs[3];
        pcs  = '{32'h1c000100, 32'h1c000001, 32'h1c000104};
        adfs = '{1'b0, 1'b1, 1'b0};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_pc    = pcs[i];
            in_adef  = adfs[i];
            tick();
        end
        in_valid  = 1'b0;
        in_adef   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_adef !== adfs[i]) begin
                errors++; $display("FAIL adef_entry i=%0d got=%b/%h/%b exp=1/%h/%b", i, out_valid, out_pc, out_adef, pcs[i], adfs[i]);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h1c00c000 + 32'(4 * i);
            tick();
        end
        in_valid = 1'b0;
        #2 resetn = 1'b0;
        q.delete();
        #1;
        checks++; if (count !== '0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset got=%0d/%b exp=0/0", count, out_valid);
        end
        tick();
        resetn = 1'b1;
        flush  = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL post_reset_flush got=%b exp=0", in_ready); end
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h1c00a000 + 32'(4 * i);
            in_inst  = 32'hcafe0000 + 32'(i);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1c00a000 + 32'(4 * i) || out_inst !== 32'hcafe0000 + 32'(i)) begin
                errors++; $display("FAIL resume i=%0d got=%b/%h/%h", i, out_valid, out_pc, out_inst);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_pc     = $urandom;
            in_inst   = $urandom;
            in_adef   = ($urandom_range(0, 7) == 0);
            #1;
            checks++; if (out_valid !== m_ov()) begin errors++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, out_valid, m_ov()); end
            checks++; if (in_ready !== m_ir())  begin errors++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, m_ir()); end
            checks++; if (count !== (PW + 1)'(q.size())) begin errors++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, q.size()); end
            if (m_ov()) begin
                checks++; if ({out_pc, out_inst, out_adef} !== m_head()) begin
                    errors++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, {out_pc, out_inst, out_adef}, m_head());
                end
            end
            tick();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_flush();
        test_adef();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
